store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
//  Write-side companion to the load path: executes SB/SH/SW.
//  Computes effective address rs1_val+imm and drives the shared data memory port.
//  Memory has no byte enables, so SB/SH use a read-modify-write (RMW) sequence.
//  Sits in the execute/memory stage beside the load path; stalls the PC while busy.
// PARAMETERS
//  MEM_RD_LAT  1  cycles from mem_addr (read mode) to valid mem_data; legal 1..4
// PORTS
//  i_clk          in   1   clock, rising edge
//  i_rst          in   1   synchronous, active-high reset
//  rs1_val        in   32  base address operand
//  rs2_val        in   32  store data operand
//  imm            in   32  sign-extended S-type offset
//  store_control  in   2   `ST_NOP/`SB/`SH/`SW; held stable by upstream while stall_pc=1
//  mem_data       in   32  memory read data, valid MEM_RD_LAT cycles after read address
//  stall_pc       out  1   1 = hold PC/instruction
//  mem_rw_mode    out  1   1 = read, 0 = write
//  mem_addr       out  32  word-aligned memory address ({ea[31:2],2'b00})
//  mem_wdata      out  32  write data, valid when mem_rw_mode=0
//  store_done     out  1   1-cycle pulse in the cycle the write is issued
//  misalign_err   out  1   1-cycle pulse for a misaligned store; no write performed
// BEHAVIOUR
//  FSM states: IDLE, RD, WAIT, WR, ERR. Outputs decode from state plus captured regs.
//  Reset values: state=IDLE, stall_pc=0, mem_rw_mode=1, mem_addr=0,
//   mem_wdata=0, store_done=0, misalign_err=0.
//  While i_rst=1, all outputs are forced to these values in the same cycle.
//  IDLE, store_control=`ST_NOP: all outputs at reset values.
//  IDLE, request (accept cycle):
//   - stall_pc=1 (combinational).
//   - Capture ea=rs1_val+imm (mod 2^32), rs2_val, and type.
//   - Misaligned (SH with ea[0]=1, or SW with ea[1:0]!=0) -> ERR.
//   - SW aligned -> WR.
//   - SB, or SH aligned -> RD.
//  RD: mem_rw_mode=1, mem_addr=aligned ea, stall_pc=1.
//   Load wait counter with MEM_RD_LAT-1, then -> WAIT.
//  WAIT: stall_pc=1, mem_addr held, mem_rw_mode=1.
//   When the counter reaches 0: sample mem_data, merge into the merge register, -> WR.
//  Merge rules:
//   - SB replaces byte lane ea[1:0] with rs2[7:0].
//   - SH replaces half lane ea[1] with rs2[15:0].
//   - SW replaces the whole word with rs2.
//  WR: mem_rw_mode=0, mem_addr=aligned ea, mem_wdata=merged word.
//   store_done=1, stall_pc=0 (PC advances at the end of this cycle), -> IDLE.
//  ERR: misalign_err=1, stall_pc=0, mem_rw_mode=1, no write, -> IDLE.
//  New requests are sampled only in IDLE; store_control in other states is ignored.
//  Latency, accept cycle to write cycle:
//   - SW: 1.
//   - SB/SH: MEM_RD_LAT+2 (MEM_RD_LAT=1: accept, RD, WAIT, WR).
//  Back-to-back stores: the next store is accepted the cycle after WR; no bubble beyond that.
//  Reset mid-operation, any state: next cycle is IDLE; a pending write is dropped, never issued.
//  mem_rw_mode=0 is asserted only in WR, for exactly one cycle per store.
// STRUCTURE
//  In processor_defines.sv:
//   - `ST_NOP=2'b00, `SB=2'b01, `SH=2'b10, `SW=2'b11.
//   - Store FSM state encodings, so the top level and the bench share them.
//  Sub-module store_merge: combinational lane merge.
//   Inputs (old word, rs2, ea[1:0], type) -> merged word.
//  Top: FSM, latency counter, capture regs, output decode.
// TESTING
//  1. SW, rs1=0x100, imm=0x4, rs2=0xDEADBEEF:
//     accept stall_pc=1; next cycle mem_rw_mode=0, addr=0x104, wdata=0xDEADBEEF, store_done=1.
//  2. SB, rs1=0x200, imm=2, rs2=0x000000AB, mem[0x200]=0x11223344:
//     RD addr=0x200 read; WR wdata=0x11AB3344.
//  3. SH, ea=0x302, rs2=0x00001234, mem[0x300]=0xAAAABBBB:
//     WR addr=0x300, wdata=0x1234BBBB.
//  4. SW at ea=0x101:
//     misalign_err pulse 1 cycle later, mem_rw_mode stays 1 throughout, store_done never set.
//  5. i_rst=1 during WAIT of an SB:
//     next cycle IDLE, all outputs at reset values, no write cycle ever seen.
//  6. MEM_RD_LAT=3, SB followed immediately by SW:
//     SB write 5 cycles after accept; SW accepted the cycle after the SB WR, written 1 cycle later.

Source files
------------

// File: rtl/store_unit_pkg.sv
// Shared store-path types: store opcode encodings, FSM states and alignment helper.
// Imported by the store unit, its merge sub-module and the bench so all agree on encodings.
package store_unit_pkg;

  typedef enum logic [1:0] {
    ST_NOP = 2'b00,
    ST_SB  = 2'b01,
    ST_SH  = 2'b10,
    ST_SW  = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4
  } store_state_e;

  // Byte stores can never be misaligned; halfwords need an even address, words a 4-byte one.
  function automatic logic isMisaligned(input store_type_e storeType, input logic [1:0] addrLow);
    logic bad;
    bad = 1'b0;
    case (storeType)
      ST_SH:   bad = addrLow[0];
      ST_SW:   bad = (addrLow != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: overlays the store data onto the word read back from memory.
module store_merge
  import store_unit_pkg::*;
(
  input  logic [31:0] oldWord_i,
  input  logic [31:0] rs2_i,
  input  logic [1:0]  byteSel_i,
  input  store_type_e type_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = oldWord_i;
    case (type_i)
      ST_SB: begin
        case (byteSel_i)
          2'd0:    merged_o[7:0]   = rs2_i[7:0];
          2'd1:    merged_o[15:8]  = rs2_i[7:0];
          2'd2:    merged_o[23:16] = rs2_i[7:0];
          default: merged_o[31:24] = rs2_i[7:0];
        endcase
      end
      ST_SH: begin
        if (byteSel_i[1]) merged_o[31:16] = rs2_i[15:0];
        else              merged_o[15:0]  = rs2_i[15:0];
      end
      ST_SW:   merged_o = rs2_i;
      default: merged_o = oldWord_i;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// SB/SH/SW execution against a word-only data memory; sub-word stores read-modify-write.
// The PC is stalled from the accept cycle until the write (or misalign error) cycle.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [1:0]  store_control,
  input  logic [31:0] mem_data,
  output logic        stall_pc,
  output logic        mem_rw_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        store_done,
  output logic        misalign_err
);

  store_state_e state_q, state_d;
  store_type_e  type_q, type_d;
  store_type_e  reqType;
  logic [31:0]  ea_q, ea_d;
  logic [31:0]  rs2_q, rs2_d;
  logic [31:0]  merge_q, merge_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  mergedWord;
  logic [31:0]  alignedAddr;

  assign reqType     = store_type_e'(store_control);
  assign alignedAddr = {ea_q[31:2], 2'b00};

  store_merge u_merge (
    .oldWord_i (mem_data),
    .rs2_i     (rs2_q),
    .byteSel_i (ea_q[1:0]),
    .type_i    (type_q),
    .merged_o  (mergedWord)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      type_q  <= ST_NOP;
      ea_q    <= '0;
      rs2_q   <= '0;
      merge_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      ea_q    <= ea_d;
      rs2_q   <= rs2_d;
      merge_q <= merge_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    ea_d         = ea_q;
    rs2_d        = rs2_q;
    merge_d      = merge_q;
    cnt_d        = cnt_q;
    stall_pc     = 1'b0;
    mem_rw_mode  = 1'b1;
    mem_addr     = '0;
    mem_wdata    = '0;
    store_done   = 1'b0;
    misalign_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (reqType != ST_NOP) begin
          ea_d    = rs1_val + imm;
          rs2_d   = rs2_val;
          type_d  = reqType;
          // A word store needs no read, so its data goes straight into the merge register.
          merge_d = rs2_val;
          if (isMisaligned(reqType, ea_d[1:0])) state_d = S_ERR;
          else if (reqType == ST_SW)            state_d = S_WR;
          else                                  state_d = S_RD;
          stall_pc = 1'b1;
        end
      end
      S_RD: begin
        cnt_d    = 2'(MEM_RD_LAT - 1);
        state_d  = S_WAIT;
        stall_pc = 1'b1;
        mem_addr = alignedAddr;
      end
      S_WAIT: begin
        stall_pc = 1'b1;
        mem_addr = alignedAddr;
        if (cnt_q == 2'd0) begin
          merge_d = mergedWord;
          state_d = S_WR;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_WR: begin
        mem_rw_mode = 1'b0;
        mem_addr    = alignedAddr;
        mem_wdata   = merge_q;
        store_done  = 1'b1;
        state_d     = S_IDLE;
      end
      S_ERR: begin
        misalign_err = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset overrides the decode in the same cycle so no write can escape while it is held.
    if (i_rst) begin
      stall_pc     = 1'b0;
      mem_rw_mode  = 1'b1;
      mem_addr     = '0;
      mem_wdata    = '0;
      store_done   = 1'b0;
      misalign_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: table of single stores plus reset-in-WAIT and back-to-back sequences.
module tb_store_unit;
  import store_unit_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        iRst;
  logic [31:0] rs1Val, rs2Val, immVal;
  logic [1:0]  storeControl;
  logic [31:0] memData;
  logic        stallPc, memRwMode, storeDone, misalignErr;
  logic [31:0] memAddr, memWdata;

  logic [31:0] presetAddr, presetWord;
  logic [31:0] rdPipe [LAT];
  int          writeCount = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  store_unit #(.MEM_RD_LAT(LAT)) dut (
    .i_clk         (clk),
    .i_rst         (iRst),
    .rs1_val       (rs1Val),
    .rs2_val       (rs2Val),
    .imm           (immVal),
    .store_control (storeControl),
    .mem_data      (memData),
    .stall_pc      (stallPc),
    .mem_rw_mode   (memRwMode),
    .mem_addr      (memAddr),
    .mem_wdata     (memWdata),
    .store_done    (storeDone),
    .misalign_err  (misalignErr)
  );

  // Memory returns presetWord for presetAddr, LAT cycles after the address; writes are counted.
  always @(posedge clk) begin
    rdPipe[0] <= (memAddr == presetAddr) ? presetWord : 32'h0;
    for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    if (memRwMode == 1'b0) writeCount <= writeCount + 1;
  end
  assign memData = rdPipe[LAT-1];

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [31:0] oldWord;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input logic [1:0] ctrl, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2);
    storeControl = ctrl;
    rs1Val       = rs1;
    immVal       = imm;
    rs2Val       = rs2;
  endtask

  // Waits for store_done/misalign_err after an accept; returns cycles taken and whether the
  // intermediate read cycles held the expected address with the PC stalled.
  task automatic waitDone(input logic [31:0] expAddr, output int lat, output logic readOk,
                          output logic seen);
    lat    = 0;
    readOk = 1'b1;
    seen   = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
      if (storeDone === 1'b1 || misalignErr === 1'b1) seen = 1'b1;
      else if (memAddr !== expAddr || memRwMode !== 1'b1 || stallPc !== 1'b1) readOk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int   lat;
    int   wrBefore;
    logic readOk, seen;
    presetAddr = v.expAddr;
    presetWord = v.oldWord;
    wrBefore   = writeCount;
    @(negedge clk);
    driveReq(v.ctrl, v.rs1, v.imm, v.rs2);
    #1;
    checkOutput($sformatf("v%0d.acceptStall", idx), 32'(stallPc), 32'd1);
    checkOutput($sformatf("v%0d.acceptRw", idx), 32'(memRwMode), 32'd1);
    waitDone(v.expAddr, lat, readOk, seen);
    checkOutput($sformatf("v%0d.finished", idx), 32'(seen), 32'd1);
    checkOutput($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.expLat));
    checkOutput($sformatf("v%0d.readPhase", idx), 32'(readOk), 32'd1);
    checkOutput($sformatf("v%0d.stallAtEnd", idx), 32'(stallPc), 32'd0);
    if (v.expErr) begin
      checkOutput($sformatf("v%0d.misalign", idx), 32'(misalignErr), 32'd1);
      checkOutput($sformatf("v%0d.noDone", idx), 32'(storeDone), 32'd0);
      checkOutput($sformatf("v%0d.errRw", idx), 32'(memRwMode), 32'd1);
    end else begin
      checkOutput($sformatf("v%0d.done", idx), 32'(storeDone), 32'd1);
      checkOutput($sformatf("v%0d.wrRw", idx), 32'(memRwMode), 32'd0);
      checkOutput($sformatf("v%0d.addr", idx), memAddr, v.expAddr);
      checkOutput($sformatf("v%0d.wdata", idx), memWdata, v.expWdata);
      checkOutput($sformatf("v%0d.noErr", idx), 32'(misalignErr), 32'd0);
    end
    storeControl = ST_NOP;
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d.writes", idx), 32'(writeCount - wrBefore), v.expErr ? 32'd0 : 32'd1);
  endtask

  initial begin
    int   lat;
    int   wrBefore;
    logic readOk, seen;

    vecs[0]  = '{ST_SW, 32'h0000_0100, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,          32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[1]  = '{ST_SB, 32'h0000_0200, 32'h0000_0002, 32'h0000_00AB, 32'h1122_3344, 32'h0000_0200, 32'h11AB_3344, 1'b0, LAT+2};
    vecs[2]  = '{ST_SH, 32'h0000_0300, 32'h0000_0002, 32'h0000_1234, 32'hAAAA_BBBB, 32'h0000_0300, 32'h1234_BBBB, 1'b0, LAT+2};
    vecs[3]  = '{ST_SW, 32'h0000_0100, 32'h0000_0001, 32'h1111_1111, 32'h0,          32'h0000_0100, 32'h0,          1'b1, 1};
    vecs[4]  = '{ST_SB, 32'h0000_0400, 32'h0000_0000, 32'hFFFF_FF5A, 32'h0102_0304, 32'h0000_0400, 32'h0102_035A, 1'b0, LAT+2};
    vecs[5]  = '{ST_SB, 32'h0000_0504, 32'hFFFF_FFFF, 32'h0000_0077, 32'hCAFE_F00D, 32'h0000_0500, 32'h77FE_F00D, 1'b0, LAT+2};
    vecs[6]  = '{ST_SH, 32'h0000_0600, 32'h0000_0000, 32'hABCD_9876, 32'h1111_2222, 32'h0000_0600, 32'h1111_9876, 1'b0, LAT+2};
    vecs[7]  = '{ST_SH, 32'h0000_0700, 32'h0000_0001, 32'h0000_5555, 32'h0,          32'h0000_0700, 32'h0,          1'b1, 1};
    vecs[8]  = '{ST_SW, 32'h0000_0700, 32'h0000_0002, 32'h0000_6666, 32'h0,          32'h0000_0700, 32'h0,          1'b1, 1};
    vecs[9]  = '{ST_SW, 32'hFFFF_FFFC, 32'h0000_0008, 32'h1357_9BDF, 32'h0,          32'h0000_0004, 32'h1357_9BDF, 1'b0, 1};
    vecs[10] = '{ST_SB, 32'h0000_0800, 32'h0000_0001, 32'h0000_00C3, 32'h0000_0000, 32'h0000_0800, 32'h0000_C300, 1'b0, LAT+2};

    presetAddr = 32'hFFFF_FFF0;
    presetWord = 32'h0;
    iRst = 1'b1;
    driveReq(ST_SW, 32'h100, 32'h0, 32'h1234_5678);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstForcedStall", 32'(stallPc), 32'd0);
    checkOutput("rstForcedRw", 32'(memRwMode), 32'd1);
    checkOutput("rstForcedDone", 32'(storeDone), 32'd0);

    @(negedge clk);
    iRst = 1'b0;
    storeControl = ST_NOP;
    #1;
    checkOutput("idleStall", 32'(stallPc), 32'd0);
    checkOutput("idleRw", 32'(memRwMode), 32'd1);
    checkOutput("idleAddr", memAddr, 32'h0);
    checkOutput("idleWdata", memWdata, 32'h0);
    checkOutput("idleDone", 32'(storeDone), 32'd0);
    checkOutput("idleErr", 32'(misalignErr), 32'd0);

    for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

    // Reset asserted during WAIT of an SB: the pending write must never appear.
    presetAddr = 32'h0000_0900;
    presetWord = 32'h5555_5555;
    wrBefore   = writeCount;
    @(negedge clk);
    driveReq(ST_SB, 32'h900, 32'h1, 32'h0000_00EE);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstWaitStall", 32'(stallPc), 32'd1);
    checkOutput("rstWaitAddr", memAddr, 32'h0000_0900);
    iRst = 1'b1;
    storeControl = ST_NOP;
    #1;
    checkOutput("rstWaitForcedStall", 32'(stallPc), 32'd0);
    checkOutput("rstWaitForcedAddr", memAddr, 32'h0);
    @(negedge clk);
    iRst = 1'b0;
    #1;
    checkOutput("rstWaitIdleStall", 32'(stallPc), 32'd0);
    checkOutput("rstWaitIdleRw", 32'(memRwMode), 32'd1);
    checkOutput("rstWaitIdleAddr", memAddr, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (storeDone === 1'b1) seen = 1'b1;
    end
    checkOutput("rstWaitNoDone", 32'(seen), 32'd0);
    checkOutput("rstWaitNoWrite", 32'(writeCount - wrBefore), 32'd0);

    // SB immediately followed by SW: the SW is accepted in the cycle right after the SB write.
    presetAddr = 32'h0000_0A00;
    presetWord = 32'h0123_4567;
    wrBefore   = writeCount;
    @(negedge clk);
    driveReq(ST_SB, 32'hA00, 32'h3, 32'h0000_005E);
    waitDone(32'h0000_0A00, lat, readOk, seen);
    checkOutput("b2bSbLatency", 32'(lat), 32'(LAT + 2));
    checkOutput("b2bSbDone", 32'(storeDone), 32'd1);
    checkOutput("b2bSbWdata", memWdata, 32'h5E23_4567);
    driveReq(ST_SW, 32'hB00, 32'h0, 32'h0BAD_F00D);
    @(negedge clk);
    #1;
    checkOutput("b2bSwAcceptStall", 32'(stallPc), 32'd1);
    checkOutput("b2bSwAcceptRw", 32'(memRwMode), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("b2bSwDone", 32'(storeDone), 32'd1);
    checkOutput("b2bSwAddr", memAddr, 32'h0000_0B00);
    checkOutput("b2bSwWdata", memWdata, 32'h0BAD_F00D);
    storeControl = ST_NOP;
    @(posedge clk);
    #1;
    checkOutput("b2bWrites", 32'(writeCount - wrBefore), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
